key_onehot_scanner: RTL
=======================

KEY_ONEHOT_SCANNER -- requirements
Module: key_onehot_scanner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive identical synchronised samples needed to accept a new key vector; legal range 2..15.
REQ-002 Port clk  input  1  single system clock, rising-edge active.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port key_in  input  8  raw, asynchronous, bouncing key lines; 1 = pressed.
REQ-005 Port onehot_out  output  8  accepted one-hot key vector, feeding the downstream 8-to-3 encoder data input.
REQ-006 Port en_n  output  1  downstream encoder enable; 1 = encoder disabled (tri-state), 0 = encode onehot_out.
REQ-007 Port valid  output  1  onehot_out holds an unconsumed key event.
REQ-008 Port ready  input  1  consumer accepts the event; transfer occurs on a rising edge with valid=1 and ready=1.
REQ-009 Port multi_err  output  1  one-cycle pulse when a debounced vector has more than one bit set.

Function
REQ-010 Each key_in bit shall pass through a 2-flop synchroniser before any other use.
REQ-011 The debouncer shall update its debounced vector only after the synchronised 8-bit vector has been identical for DEB_CYCLES consecutive cycles; any bit change restarts the count.
REQ-012 Glitches shorter than DEB_CYCLES cycles shall never change the debounced vector.
REQ-013 The FSM shall have exactly the states IDLE, EVAL, HOLD, RELEASE.
REQ-014 IDLE: leave for EVAL on the cycle the debounced vector becomes non-zero; otherwise remain.
REQ-015 EVAL (one cycle): exactly one bit set -> capture vector into onehot_out and go to HOLD; more than one bit set -> pulse multi_err and go to RELEASE.
REQ-016 HOLD: valid=1, en_n=0; onehot_out and valid shall stay constant until transfer; on transfer go to RELEASE.
REQ-017 Key release during HOLD shall not drop valid or alter onehot_out.
REQ-018 RELEASE: valid=0, en_n=1; return to IDLE only when the debounced vector is all-zero; new presses are ignored until then.
REQ-019 A key vector stable from rising edge k shall produce valid=1 first at edge k+DEB_CYCLES+3.
REQ-020 en_n shall equal the inverse of valid at all times; onehot_out shall be 8'h00 whenever valid=0.
REQ-021 If ready is high on the first HOLD cycle, the transfer completes on that edge, so valid is high for exactly one cycle.
REQ-022 multi_err shall be high for exactly one cycle per multi-key event and never concurrently with valid.

Reset
REQ-023 While rst_n=0: synchronisers, debounce counter and debounced vector = 0; state = IDLE; onehot_out=8'h00, valid=0, multi_err=0, en_n=1.
REQ-024 Reset assertion shall take effect asynchronously, including mid-HOLD (pending event discarded); deassertion shall be sampled synchronously to clk.

Structure
REQ-025 A shared package shall hold the FSM state type (IDLE/EVAL/HOLD/RELEASE), the key-width constant 8, the code-width constant 3 and the DEB_CYCLES default.
REQ-026 Synchroniser plus debounce shall be one sub-module, key_sync_debounce (8-bit in, 8-bit debounced out, DEB_CYCLES parameter); the FSM and handshake stay in the top.

Verification (DEB_CYCLES=4)
REQ-027 key_in=8'h04 clean from edge k, ready=1 -> valid=1, onehot_out=8'h04, en_n=0 at edge k+7 only; valid=0 at k+8.
REQ-028 key_in=8'h10 bouncing 1-cycle pulses for 10 cycles, then stable, ready=0 -> no valid during bounce; valid with onehot_out=8'h10 held until ready raised, then one transfer.
REQ-029 key_in=8'h81 stable -> single multi_err pulse, valid never asserts, en_n stays 1; new 8'h02 accepted only after key_in=0 has been debounced.
REQ-030 8'h40 in HOLD with ready=0, key released -> valid and onehot_out=8'h40 unchanged until ready=1.
REQ-031 rst_n pulled low mid-HOLD -> valid=0, onehot_out=8'h00, en_n=1 immediately; after release, held key 8'h01 produces a fresh event only once debounced again.

Source files
------------

// File: rtl/key_onehot_scanner_pkg.sv
// Shared types and constants for the one-hot key scanner.
// Holds the FSM state type, the key/code widths, the debounce default and a bit-count helper.
package key_onehot_scanner_pkg;

  localparam int KEY_W          = 8;
  localparam int CODE_W         = 3;
  localparam int DEB_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    HOLD,
    RELEASE
  } state_t;

  // Number of pressed keys; CODE_W+1 bits covers 0..KEY_W.
  function automatic logic [CODE_W:0] key_count(input logic [KEY_W-1:0] v);
    logic [CODE_W:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + {{CODE_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/key_onehot_scanner_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for the raw key lines.
// Latency: key_deb follows a stable key_in DEB_CYCLES+1 edges after the first sampling edge; no backpressure.
module key_sync_debounce
  import key_onehot_scanner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_deb
);

  localparam logic [3:0] CNT_MAX  = 4'(DEB_CYCLES);
  localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] sync2;
  logic [KEY_W-1:0] cand;
  logic [3:0]       cnt;

  // cand tracks the latest synchronised vector; cnt counts how many samples it has held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      cnt     <= '0;
      key_deb <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= 4'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          key_deb <= cand;
        end
      end
    end
  end

endmodule

// File: rtl/key_onehot_scanner.sv
// Debounced one-hot key scanner driving an 8-to-3 encoder, with valid/ready event handshake.
// Latency: valid rises DEB_CYCLES+3 edges after key_in settles; valid/onehot_out hold until ready.
module key_onehot_scanner
  import key_onehot_scanner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] onehot_out,
  output logic             en_n,
  output logic             valid,
  input  logic             ready,
  output logic             multi_err
);

  logic [KEY_W-1:0] key_deb;
  state_t           state;

  key_sync_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sync_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .key_deb(key_deb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      onehot_out <= '0;
      valid      <= 1'b0;
      en_n       <= 1'b1;
      multi_err  <= 1'b0;
    end else begin
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_deb != '0) state <= EVAL;
        end
        EVAL: begin
          if (key_count(key_deb) == 4'd1) begin
            onehot_out <= key_deb;
            valid      <= 1'b1;
            en_n       <= 1'b0;
            state      <= HOLD;
          end else if (key_count(key_deb) == 4'd0) begin
            // Vector vanished between detection and evaluation: nothing to report.
            state <= IDLE;
          end else begin
            multi_err <= 1'b1;
            state     <= RELEASE;
          end
        end
        HOLD: begin
          // Key state is ignored here so a release cannot disturb a pending event.
          if (ready) begin
            onehot_out <= '0;
            valid      <= 1'b0;
            en_n       <= 1'b1;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_deb == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
